// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
// Optional feature macro used by div_unit: DIV_EARLY_OUT_EN.
package div_pkg;

  // Default operand width of the MIPS datapath.
  localparam int DIV_WIDTH = 32;

  // Counter must hold the value WIDTH itself.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  // Divide-by-zero quotient: every bit set.
  localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

  // State encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
// Invariant: rem_i < divisor_i, so the remainder always fits in WIDTH bits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH:0]   divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  // Shift {rem, quot} left, try subtracting the divisor, keep it if non-negative.
  always_comb begin
    rem_sh = {rem_i, quot_i[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {1'b0, divisor_i};
    quot_o = {quot_i[WIDTH-2:0], 1'b0};
    rem_o  = rem_sh[WIDTH-1:0];
    // A successful trial is always below the divisor, so bit WIDTH is zero too.
    if (trial[WIDTH+1:WIDTH] == 2'b00) begin
      rem_o     = trial[WIDTH-1:0];
      quot_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for the E stage (DIV / DIVU).
// Produces {remainder, quotient} for HI/LO and stalls the pipeline while busy.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when the divisor is zero
// or the dividend magnitude is below the divisor magnitude.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               divE,
  input  logic               signed_divE,
  input  logic               flushE,
  input  logic [WIDTH-1:0]   srcaE,
  input  logic [WIDTH-1:0]   srcbE,
  output logic [2*WIDTH-1:0] div_resultE,
  output logic               div_readyE,
  output logic               div_stallE
);

  localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] QUOT_DIV0 = {WIDTH{DIV_ZERO_QUOT_BIT}};
  localparam logic [WIDTH-1:0] QUOT_NONE = {WIDTH{1'b0}};

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH:0]     divisor_q, divisor_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   step_rem, step_quot;
  logic [WIDTH-1:0]   fix_rem, fix_quot;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH:0]     ext_b, mag_b;
  logic               stall, ready;
`ifdef DIV_EARLY_OUT_EN
  logic               early_out;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .quot_i   (quot_q),
    .divisor_i(divisor_q),
    .rem_o    (step_rem),
    .quot_o   (step_quot)
  );

  // Operand magnitudes. The dividend magnitude is read as unsigned, so WIDTH
  // bits already hold |most negative|; the divisor keeps an extra bit.
  always_comb begin
    mag_a = (signed_divE && srcaE[WIDTH-1]) ? (~srcaE + 1'b1) : srcaE;
    ext_b = {signed_divE & srcbE[WIDTH-1], srcbE};
    mag_b = ext_b[WIDTH] ? (~ext_b + 1'b1) : ext_b;
`ifdef DIV_EARLY_OUT_EN
    early_out = (srcbE == QUOT_NONE) || ({1'b0, mag_a} < mag_b);
`endif
  end

  // Sign correction applied to the output of the final iteration.
  always_comb begin
    fix_rem  = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
    fix_quot = div0_q ? QUOT_DIV0 : (neg_quot_q ? (~step_quot + 1'b1) : step_quot);
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;
    result_d   = result_q;
    stall      = 1'b0;
    ready      = 1'b0;
    case (state_q)
      IDLE: begin
        // Reset gates the combinational stall so all outputs read zero in reset.
        stall = divE & ~flushE & rst;
        if (divE && !flushE) begin
          rem_d      = '0;
          quot_d     = mag_a;
          divisor_d  = mag_b;
          neg_quot_d = signed_divE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
          neg_rem_d  = signed_divE & srcaE[WIDTH-1];
          div0_d     = (srcbE == QUOT_NONE);
          cnt_d      = CNT_W'(WIDTH);
          state_d    = BUSY;
`ifdef DIV_EARLY_OUT_EN
          if (early_out) begin
            state_d  = DONE;
            result_d = {srcaE, (srcbE == QUOT_NONE) ? QUOT_DIV0 : QUOT_NONE};
          end
`endif
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (flushE) begin
          state_d = IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = {fix_rem, fix_quot};
          end
        end
      end
      DONE: begin
        // divE is still the same instruction here; never restart from DONE.
        ready   = ~flushE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
      result_q   <= result_d;
    end
  end

  assign div_resultE = result_q;
  assign div_readyE  = ready;
  assign div_stallE  = stall;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Honours DIV_EARLY_OUT_EN for the expected latency of short divides.
module tb_div_unit;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           divE = 1'b0;
  logic           signed_divE = 1'b0;
  logic           flushE = 1'b0;
  logic [W-1:0]   srcaE = '0;
  logic [W-1:0]   srcbE = '0;
  logic [2*W-1:0] div_resultE;
  logic           div_readyE;
  logic           div_stallE;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] last_exp = '0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .divE       (divE),
    .signed_divE(signed_divE),
    .flushE     (flushE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .div_resultE(div_resultE),
    .div_readyE (div_readyE),
    .div_stallE (div_stallE)
  );

  // Expected cycle (1 = acceptance cycle) in which ready pulses.
  function automatic int exp_cyc(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic [W:0] ma, mb;
    logic early;
    ma = (sgn && a[W-1]) ? ({1'b0, ~a} + 1'b1) : {1'b0, a};
    mb = (sgn && b[W-1]) ? ({1'b0, ~b} + 1'b1) : {1'b0, b};
    early = (b == '0) || (ma < mb);
    return (EARLY && early) ? 2 : 34;
  endfunction

  // One divide with divE held until DONE, then optional idle tail checks.
  task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int tail);
    int cyc_e, ready_cyc, stall_cnt, ready_cnt;
    logic [2*W-1:0] res;
    cyc_e = exp_cyc(a, b, sgn);
    ready_cyc = 0;
    stall_cnt = 0;
    res = 'x;
    divE = 1'b1; signed_divE = sgn; srcaE = a; srcbE = b;
    for (int c = 1; c <= 40 && ready_cyc == 0; c++) begin
      @(negedge clk);
      if (div_stallE) stall_cnt++;
      if (div_readyE) begin
        ready_cyc = c;
        res = div_resultE;
        checks++;
        if (div_stallE !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_at_ready got %b expected 0", name, div_stallE);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ready_cyc !== cyc_e) begin
      errors++;
      $display("FAIL %s ready_cycle got %0d expected %0d", name, ready_cyc, cyc_e);
    end
    checks++;
    if (res !== {er, eq}) begin
      errors++;
      $display("FAIL %s result got %h expected %h", name, res, {er, eq});
    end
    checks++;
    if (stall_cnt !== cyc_e - 1) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d expected %0d", name, stall_cnt, cyc_e - 1);
    end
    last_exp = {er, eq};
    $display("div %s: a=%h b=%h signed=%0b -> result=%h ready_cycle=%0d stall_cycles=%0d",
             name, a, b, sgn, res, ready_cyc, stall_cnt);
    if (tail > 0) begin
      divE = 1'b0;
      ready_cnt = 0;
      stall_cnt = 0;
      for (int c = 0; c < tail; c++) begin
        @(negedge clk);
        if (div_readyE) ready_cnt++;
        if (div_stallE) stall_cnt++;
        @(posedge clk); #1;
      end
      checks++;
      if (ready_cnt !== 0 || stall_cnt !== 0) begin
        errors++;
        $display("FAIL %s tail_quiet got ready=%0d stall=%0d expected 0/0", name, ready_cnt, stall_cnt);
      end
      checks++;
      if (div_resultE !== last_exp) begin
        errors++;
        $display("FAIL %s result_hold got %h expected %h", name, div_resultE, last_exp);
      end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (div_resultE !== '0 || div_readyE !== 1'b0 || div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got res=%h rdy=%b stall=%b expected 0/0/0", div_resultE, div_readyE, div_stallE);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    $display("reset released: res=%h rdy=%b stall=%b", div_resultE, div_readyE, div_stallE);
  endtask

  task automatic test_divu;
    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 3);
    run_div("divu_hex", 32'h12345678, 32'h100, 1'b0, 32'h00123456, 32'h78, 0);
    run_div("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 2);
  endtask

  task automatic test_signed;
    run_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    run_div("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 0);
    run_div("div_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 2);
  endtask

  task automatic test_boundary;
    run_div("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 0);
    run_div("divu_5_0", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 0);
    run_div("div_m5_0", 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 0);
    run_div("divu_3_9", 32'd3, 32'd9, 1'b0, 32'd0, 32'd3, 2);
  endtask

  task automatic test_flush;
    int ready_cnt;
    // Flush in IDLE: no stall, no start.
    divE = 1'b1; flushE = 1'b1; signed_divE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
    @(negedge clk);
    checks++;
    if (div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_stall got %b expected 0", div_stallE);
    end
    @(posedge clk); #1;
    divE = 1'b0; flushE = 1'b0;
    @(negedge clk);
    checks++;
    if (div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_nostart got stall=%b expected 0", div_stallE);
    end
    @(posedge clk); #1;
    // Start 100/7 and flush during the tenth BUSY cycle (cycle 11).
    divE = 1'b1;
    repeat (10) begin @(negedge clk); @(posedge clk); #1; end
    flushE = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    flushE = 1'b0; divE = 1'b0;
    @(negedge clk);
    checks++;
    if (div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_idle got stall=%b expected 0", div_stallE);
    end
    ready_cnt = 0;
    repeat (40) begin
      if (div_readyE) ready_cnt++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    checks++;
    if (ready_cnt !== 0) begin
      errors++;
      $display("FAIL flush_no_ready got %0d pulses expected 0", ready_cnt);
    end
    checks++;
    if (div_resultE !== last_exp) begin
      errors++;
      $display("FAIL flush_result_kept got %h expected %h", div_resultE, last_exp);
    end
    $display("flush at busy cycle 10: result=%h ready_pulses=%0d", div_resultE, ready_cnt);
    run_div("after_flush", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0);
  endtask

  task automatic test_back_to_back;
    run_div("b2b_first", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 0);
    run_div("b2b_second", 32'hFFFFFC18, 32'd3, 1'b1, 32'hFFFFFEB3, 32'hFFFFFFFF, 4);
  endtask

  task automatic test_reset_mid;
    int ready_cnt;
    divE = 1'b1; signed_divE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
    repeat (6) begin @(negedge clk); @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (div_resultE !== '0 || div_readyE !== 1'b0 || div_stallE !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got res=%h rdy=%b stall=%b expected 0/0/0", div_resultE, div_readyE, div_stallE);
    end
    divE = 1'b0;
    @(negedge clk); rst = 1'b1;
    ready_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_readyE || div_stallE) ready_cnt++;
    end
    @(posedge clk); #1;
    checks++;
    if (ready_cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d active cycles expected 0", ready_cnt);
    end
    $display("reset mid-busy: result=%h active_cycles_after=%0d", div_resultE, ready_cnt);
    last_exp = '0;
    run_div("after_reset", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 2);
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_boundary();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the execute stage of the 5-stage MIPS pipeline, downstream of the controller.
- Consumes the controller's divE/signed_divE decode outputs and the E-stage operands.
- Produces {remainder, quotient} for the HI/LO write path, plus a stall request to the hazard unit while the divide is in flight.

Parameters:
- WIDTH, 32, operand width in bits.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous reset, active-low
- divE  input  1  divide instruction in E (start request)
- signed_divE  input  1  1 = DIV (signed), 0 = DIVU
- flushE  input  1  synchronous annul of the E-stage instruction
- srcaE  input  WIDTH  dividend (rs)
- srcbE  input  WIDTH  divisor (rt)
- div_resultE  output  2*WIDTH  {remainder (HI), quotient (LO)}
- div_readyE  output  1  one-cycle result-valid pulse
- div_stallE  output  1  stall request to the hazard unit

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE, div_resultE = 0, div_readyE = 0, div_stallE = 0, counter = 0, internal registers = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - divE = 1 and flushE = 0: latch operand magnitudes and sign flags (signed_divE), load counter = WIDTH, go to BUSY.
  - div_stallE = divE & ~flushE, combinational in the same cycle.
- BUSY:
  - One restoring step per cycle: shift {rem, quot} left 1; trial = rem - |divisor|; if non-negative, keep it and set the quotient LSB.
  - Counter decrements each cycle; at counter == 1 the final step executes and the state moves to DONE.
  - div_stallE = 1 throughout.
- DONE:
  - div_resultE is registered with sign correction: quotient negated if signed and sign(a) != sign(b); remainder negated if signed and a < 0.
  - div_readyE = 1 for exactly this cycle; div_stallE = 0 so the instruction advances to M.
  - divE is ignored here; the same instruction is still present and must not restart. Next state is IDLE.
- Latency: start cycle, then WIDTH BUSY cycles, then DONE, i.e. WIDTH+2 cycles from acceptance to ready. With WIDTH = 32: stall is high for 33 cycles, ready pulses in cycle 34.
- div_resultE holds its value after DONE until the next DONE.
- flushE = 1 in any state: return to IDLE next cycle, no ready pulse, div_resultE unchanged. flushE has priority over divE.
- Divide by zero: quotient = all ones, remainder = dividend. No sign correction. Normal latency.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0. This falls out of two's-complement magnitude arithmetic.
- Magnitudes are computed in WIDTH+1 bits so that |0x80000000| is representable.
- Reset asserted mid-operation: immediate return to the reset state above.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if divisor == 0 or |dividend| < |divisor|, skip BUSY and go straight to DONE. Quotient = 0 (or all ones for divide by zero), remainder = dividend. Stall lasts 1 cycle, ready pulses in cycle 2.
- Undefined: fixed WIDTH+2 latency for all operands.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, BUSY, DONE) as 2-bit localparams
  - DIV_CNT_W = $clog2(WIDTH+1)
  - divide-by-zero quotient constant
- Sub-module div_step: purely combinational single restoring step (inputs rem, quot, divisor; outputs next rem, next quot), instantiated once in the BUSY datapath.

Test Plan:
- DIVU 100 / 7 -> after 34 cycles div_readyE = 1 and div_resultE = {32'd2, 32'd14}; div_stallE high cycles 1-33 exactly.
- DIV -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7 / -2 -> quotient -3, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. DIVU 5 / 0 -> quotient 0xFFFFFFFF, remainder 5.
- Start 100 / 7, assert flushE at BUSY cycle 10 -> IDLE next cycle, no ready pulse, div_resultE keeps its prior value. New start accepted immediately afterwards and completes correctly.
- Hold divE high through DONE (as the stalled pipeline does) -> exactly one ready pulse, no restart. Back-to-back divide in the following cycle is accepted.
- Drop rst low mid-BUSY -> all outputs 0 asynchronously. With DIV_EARLY_OUT_EN defined, DIVU 3 / 9 -> ready in cycle 2 with {32'd3, 32'd0}.
